// File: rtl/mem_dump_if.sv
// rtl/mem_dump_if.sv - memory requester and UART transmit bundle used by mem_dump
interface mem_dump_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_rdy;
  logic                  mem_cplt;
  logic [7:0]            serial_data_out;
  logic                  serial_out_en;
  logic                  serial_out_rdy;

  // the dump engine: issues reads and transmit strobes
  modport master (
    output mem_addr, mem_data_in, mem_r_en, mem_w_en, serial_data_out, serial_out_en,
    input  mem_data_out, mem_rdy, mem_cplt, serial_out_rdy
  );

  // the memory controller port and the UART transmitter
  modport slave (
    input  mem_addr, mem_data_in, mem_r_en, mem_w_en, serial_data_out, serial_out_en,
    output mem_data_out, mem_rdy, mem_cplt, serial_out_rdy
  );
endinterface

// File: rtl/mem_dump.sv
// rtl/mem_dump.sv - reads a word range from SDRAM and streams it out the UART with a checksum
module mem_dump #(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 16,
  parameter int COUNT_WIDTH   = 16,
  parameter int SEND_CHECKSUM = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  mem_dump_if.master             bus
);

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    TX_HI,
    TX_HI_GAP,
    TX_LO,
    TX_LO_GAP,
    TX_SUM,
    TX_SUM_GAP,
    FINISH
  } state_t;

  state_t                 state_q;
  logic                   busy_q;
  logic                   done_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [7:0]             checksum_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [7:0]             sdo_q;

  logic                   tx_state;
  logic                   tx_fire;
  logic [7:0]             tx_byte;

  // select the byte belonging to the current transmit state
  always_comb begin
    tx_byte = checksum_q;
    case (state_q)
      TX_HI:   tx_byte = data_q[DATA_WIDTH-1 -: 8];
      TX_LO:   tx_byte = data_q[7:0];
      default: tx_byte = checksum_q;
    endcase
  end

  // strobes are qualified by the handshake in the same cycle so no cycle is lost
  assign tx_state = (state_q == TX_HI) || (state_q == TX_LO) || (state_q == TX_SUM);
  assign tx_fire  = tx_state && bus.serial_out_rdy;

  assign bus.mem_addr        = addr_q;
  assign bus.mem_data_in     = '0;
  assign bus.mem_w_en        = 1'b0;
  assign bus.mem_r_en        = (state_q == RD_REQ) && bus.mem_rdy;
  assign bus.serial_out_en   = tx_fire;
  // the last strobed byte is held through the gap and wait states
  assign bus.serial_data_out = tx_fire ? tx_byte : sdo_q;
  assign busy                = busy_q;
  assign done                = done_q;

  // dump sequencer: one outstanding read, then high byte, low byte, and finally the checksum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      checksum_q  <= '0;
      data_q      <= '0;
      sdo_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            addr_q      <= start_addr;
            remaining_q <= word_count;
            checksum_q  <= '0;
            if (word_count != '0) begin
              busy_q  <= 1'b1;
              state_q <= RD_REQ;
            end else if (SEND_CHECKSUM != 0) begin
              busy_q  <= 1'b1;
              state_q <= TX_SUM;
            end else begin
              // nothing to send at all: report completion straight away
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        RD_REQ: begin
          if (bus.mem_rdy) begin
            // a completion coinciding with the request is taken here
            if (bus.mem_cplt) begin
              data_q  <= bus.mem_data_out;
              state_q <= TX_HI;
            end else begin
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (bus.mem_cplt) begin
            data_q  <= bus.mem_data_out;
            state_q <= TX_HI;
          end
        end
        TX_HI: begin
          if (bus.serial_out_rdy) begin
            sdo_q      <= tx_byte;
            checksum_q <= checksum_q + tx_byte;
            state_q    <= TX_HI_GAP;
          end
        end
        TX_HI_GAP: begin
          state_q <= TX_LO;
        end
        TX_LO: begin
          if (bus.serial_out_rdy) begin
            sdo_q      <= tx_byte;
            checksum_q <= checksum_q + tx_byte;
            state_q    <= TX_LO_GAP;
          end
        end
        TX_LO_GAP: begin
          remaining_q <= remaining_q - COUNT_WIDTH'(1);
          addr_q      <= addr_q + ADDR_WIDTH'(1);
          if (remaining_q != COUNT_WIDTH'(1)) begin
            state_q <= RD_REQ;
          end else if (SEND_CHECKSUM != 0) begin
            state_q <= TX_SUM;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        TX_SUM: begin
          if (bus.serial_out_rdy) begin
            sdo_q   <= tx_byte;
            state_q <= TX_SUM_GAP;
          end
        end
        TX_SUM_GAP: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= FINISH;
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump.sv
// tb/tb_mem_dump.sv - directed self-checking bench for mem_dump
module tb_mem_dump;

  logic        clk;
  logic        rst_n;
  logic        start, busy, done;
  logic [23:0] start_addr;
  logic [15:0] word_count;
  logic        start1, busy1, done1;
  logic [23:0] start_addr1;
  logic [15:0] word_count1;

  mem_dump_if #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) if0 ();
  mem_dump_if #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) if1 ();

  mem_dump #(.ADDR_WIDTH(24), .DATA_WIDTH(16), .COUNT_WIDTH(16), .SEND_CHECKSUM(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .word_count(word_count),
    .busy(busy), .done(done), .bus(if0)
  );

  mem_dump #(.ADDR_WIDTH(24), .DATA_WIDTH(16), .COUNT_WIDTH(16), .SEND_CHECKSUM(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .start_addr(start_addr1), .word_count(word_count1),
    .busy(busy1), .done(done1), .bus(if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  // environment model state
  int          cyc;
  logic [23:0] rd_addrs[$];
  logic [7:0]  tx_bytes[$];
  int          tx_cyc[$];
  int          viol;
  int          done_cnt;
  int          lat = 1;
  int          uart_time = 0;
  int          stall_cfg = 0;
  int          stall_cnt, uart_cnt, pend_cnt;
  logic        outstanding;
  logic [15:0] pend_data;
  logic [15:0] mem [logic [23:0]];
  int          r1, s1, d1;
  int          rd_b, tx_b, dn_b, vi_b;

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0000;
  endfunction

  // memory controller + UART model for dut0; inputs change on negedge, outputs sampled 1ns later
  initial begin
    if0.mem_rdy = 1'b1; if0.mem_cplt = 1'b0; if0.mem_data_out = '0; if0.serial_out_rdy = 1'b1;
    cyc = 0; viol = 0; done_cnt = 0; stall_cnt = 0; uart_cnt = 0; pend_cnt = 0;
    outstanding = 1'b0; pend_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if0.mem_cplt = 1'b0;
      if (!rst_n) begin pend_cnt = 0; outstanding = 1'b0; uart_cnt = 0; stall_cnt = 0; end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin if0.mem_cplt = 1'b1; if0.mem_data_out = pend_data; outstanding = 1'b0; end
      end
      if (start === 1'b1) stall_cnt = stall_cfg;
      if0.mem_rdy = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      if0.serial_out_rdy = (uart_cnt == 0);
      if (uart_cnt > 0) uart_cnt--;
      #1;
      if (if0.mem_w_en !== 1'b0 || if0.mem_data_in !== 16'h0000) viol++;
      if (if0.mem_r_en === 1'b1) begin
        if (!if0.mem_rdy || outstanding) viol++;
        rd_addrs.push_back(if0.mem_addr);
        if (lat == 0) begin
          if0.mem_cplt = 1'b1; if0.mem_data_out = mem_word(if0.mem_addr);
        end else begin
          pend_cnt = lat; pend_data = mem_word(if0.mem_addr); outstanding = 1'b1;
        end
      end
      if (if0.serial_out_en === 1'b1) begin
        if (!if0.serial_out_rdy) viol++;
        tx_bytes.push_back(if0.serial_data_out);
        tx_cyc.push_back(cyc);
        uart_cnt = uart_time;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // idle environment for the checksum-less instance
  initial begin
    if1.mem_rdy = 1'b1; if1.mem_cplt = 1'b0; if1.mem_data_out = '0; if1.serial_out_rdy = 1'b1;
    r1 = 0; s1 = 0; d1 = 0;
    forever begin
      @(negedge clk); #1;
      if (if1.mem_r_en === 1'b1) r1++;
      if (if1.serial_out_en === 1'b1) s1++;
      if (done1 === 1'b1) d1++;
    end
  end

  task automatic run_dump(input logic [23:0] a, input logic [15:0] n, input int glitch_at,
                          input int tail, output int busy_low, output int got_done);
    rd_b = rd_addrs.size(); tx_b = tx_bytes.size(); dn_b = done_cnt; vi_b = viol;
    busy_low = 0; got_done = 0;
    @(negedge clk); #2;
    start = 1'b1; start_addr = a; word_count = n;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      start = 1'b0;
      if (done_cnt != dn_b) begin got_done = 1; break; end
      if (busy !== 1'b1) busy_low++;
      if (i == glitch_at) begin start = 1'b1; start_addr = 24'h000300; word_count = 16'd5; end
    end
    if (tail > 0) begin repeat (tail) @(negedge clk); #2; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_addr = '0; word_count = '0;
    start1 = 1'b0; start_addr1 = '0; word_count1 = '0;
    repeat (3) @(negedge clk); #2;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (if0.mem_r_en !== 1'b0) $display("FAIL reset_r_en: got %b expected 0", if0.mem_r_en); else pass_cnt++;
    total_cnt++; if (if0.serial_out_en !== 1'b0) $display("FAIL reset_tx_en: got %b expected 0", if0.serial_out_en); else pass_cnt++;
    total_cnt++; if (if0.mem_addr !== 24'h0) $display("FAIL reset_addr: got %h expected 000000", if0.mem_addr); else pass_cnt++;
    total_cnt++; if (if0.serial_data_out !== 8'h00) $display("FAIL reset_sdo: got %h expected 00", if0.serial_data_out); else pass_cnt++;
    total_cnt++; if (busy1 !== 1'b0 || done1 !== 1'b0) $display("FAIL reset_dut1: got busy=%b done=%b expected 0 0", busy1, done1); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int bl, gd;
    logic [7:0] exp_b[$];
    mem[24'h000010] = 16'hA55A;
    lat = 2; uart_time = 3; stall_cfg = 0;
    exp_b = '{8'hA5, 8'h5A, 8'hFF};
    run_dump(24'h000010, 16'd1, -1, 6, bl, gd);
    total_cnt++; if (gd !== 1) $display("FAIL single_done_timeout: got %0d expected 1", gd); else pass_cnt++;
    total_cnt++; if (rd_addrs.size() - rd_b !== 1) $display("FAIL single_reads: got %0d expected 1", rd_addrs.size() - rd_b); else pass_cnt++;
    total_cnt++; if (rd_addrs.size() <= rd_b || rd_addrs[rd_b] !== 24'h000010) $display("FAIL single_addr: got %0d reads expected addr 000010", rd_addrs.size() - rd_b); else pass_cnt++;
    total_cnt++; if (tx_bytes.size() - tx_b !== exp_b.size()) $display("FAIL single_nbytes: got %0d expected %0d", tx_bytes.size() - tx_b, exp_b.size()); else pass_cnt++;
    for (int k = 0; k < exp_b.size(); k++) begin
      total_cnt++;
      if (tx_b + k >= tx_bytes.size()) $display("FAIL single_byte%0d: got none expected %h", k, exp_b[k]);
      else if (tx_bytes[tx_b + k] !== exp_b[k]) $display("FAIL single_byte%0d: got %h expected %h", k, tx_bytes[tx_b + k], exp_b[k]);
      else pass_cnt++;
    end
    total_cnt++; if (done_cnt - dn_b !== 1) $display("FAIL single_done_pulses: got %0d expected 1", done_cnt - dn_b); else pass_cnt++;
    total_cnt++; if (bl !== 0) $display("FAIL single_busy_low: got %0d cycles expected 0", bl); else pass_cnt++;
    total_cnt++; if (viol - vi_b !== 0) $display("FAIL single_protocol: got %0d violations expected 0", viol - vi_b); else pass_cnt++;
  endtask

  task automatic test_multi_stall();
    int bl, gd;
    logic [7:0] exp_b[$];
    mem[24'h000100] = 16'h0102; mem[24'h000101] = 16'h0304; mem[24'h000102] = 16'h0506;
    lat = 3; uart_time = 2; stall_cfg = 5;
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
    run_dump(24'h000100, 16'd3, -1, 2, bl, gd);
    stall_cfg = 0;
    total_cnt++; if (gd !== 1) $display("FAIL multi_done_timeout: got %0d expected 1", gd); else pass_cnt++;
    total_cnt++; if (rd_addrs.size() - rd_b !== 3) $display("FAIL multi_reads: got %0d expected 3", rd_addrs.size() - rd_b); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (rd_b + k >= rd_addrs.size()) $display("FAIL multi_addr%0d: got none expected %h", k, 24'h000100 + k);
      else if (rd_addrs[rd_b + k] !== 24'h000100 + k) $display("FAIL multi_addr%0d: got %h expected %h", k, rd_addrs[rd_b + k], 24'h000100 + k);
      else pass_cnt++;
    end
    total_cnt++; if (tx_bytes.size() - tx_b !== exp_b.size()) $display("FAIL multi_nbytes: got %0d expected %0d", tx_bytes.size() - tx_b, exp_b.size()); else pass_cnt++;
    for (int k = 0; k < exp_b.size(); k++) begin
      total_cnt++;
      if (tx_b + k >= tx_bytes.size()) $display("FAIL multi_byte%0d: got none expected %h", k, exp_b[k]);
      else if (tx_bytes[tx_b + k] !== exp_b[k]) $display("FAIL multi_byte%0d: got %h expected %h", k, tx_bytes[tx_b + k], exp_b[k]);
      else pass_cnt++;
    end
    total_cnt++; if (viol - vi_b !== 0) $display("FAIL multi_protocol: got %0d violations expected 0", viol - vi_b); else pass_cnt++;
    total_cnt++; if (bl !== 0) $display("FAIL multi_busy_low: got %0d cycles expected 0", bl); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int bl, gd;
    logic [7:0] exp_b[$];
    mem[24'hFFFFFF] = 16'h1234; mem[24'h000000] = 16'hABCD;
    lat = 1; uart_time = 1;
    exp_b = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    run_dump(24'hFFFFFF, 16'd2, -1, 2, bl, gd);
    total_cnt++; if (gd !== 1) $display("FAIL wrap_done_timeout: got %0d expected 1", gd); else pass_cnt++;
    total_cnt++; if (rd_addrs.size() - rd_b !== 2) $display("FAIL wrap_reads: got %0d expected 2", rd_addrs.size() - rd_b); else pass_cnt++;
    total_cnt++; if (rd_addrs.size() < rd_b + 2 || rd_addrs[rd_b] !== 24'hFFFFFF || rd_addrs[rd_b + 1] !== 24'h000000)
      $display("FAIL wrap_addrs: got %0d reads expected FFFFFF then 000000", rd_addrs.size() - rd_b); else pass_cnt++;
    for (int k = 0; k < exp_b.size(); k++) begin
      total_cnt++;
      if (tx_b + k >= tx_bytes.size()) $display("FAIL wrap_byte%0d: got none expected %h", k, exp_b[k]);
      else if (tx_bytes[tx_b + k] !== exp_b[k]) $display("FAIL wrap_byte%0d: got %h expected %h", k, tx_bytes[tx_b + k], exp_b[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_count();
    int bl, gd, rb1, sb1, db1;
    lat = 1; uart_time = 2;
    run_dump(24'h000050, 16'd0, -1, 4, bl, gd);
    total_cnt++; if (gd !== 1) $display("FAIL zero_done_timeout: got %0d expected 1", gd); else pass_cnt++;
    total_cnt++; if (rd_addrs.size() - rd_b !== 0) $display("FAIL zero_reads: got %0d expected 0", rd_addrs.size() - rd_b); else pass_cnt++;
    total_cnt++; if (tx_bytes.size() - tx_b !== 1) $display("FAIL zero_nbytes: got %0d expected 1", tx_bytes.size() - tx_b); else pass_cnt++;
    total_cnt++; if (tx_bytes.size() <= tx_b || tx_bytes[tx_b] !== 8'h00) $display("FAIL zero_sum_byte: got %0d bytes expected a single 00", tx_bytes.size() - tx_b); else pass_cnt++;
    total_cnt++; if (done_cnt - dn_b !== 1) $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt - dn_b); else pass_cnt++;
    rb1 = r1; sb1 = s1; db1 = d1;
    @(negedge clk); #2;
    start1 = 1'b1; start_addr1 = 24'h000040; word_count1 = 16'd0;
    @(negedge clk); #2;
    start1 = 1'b0;
    repeat (8) @(negedge clk); #2;
    total_cnt++; if (d1 - db1 !== 1) $display("FAIL nosum_done_pulses: got %0d expected 1", d1 - db1); else pass_cnt++;
    total_cnt++; if (r1 - rb1 !== 0) $display("FAIL nosum_reads: got %0d expected 0", r1 - rb1); else pass_cnt++;
    total_cnt++; if (s1 - sb1 !== 0) $display("FAIL nosum_strobes: got %0d expected 0", s1 - sb1); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bl, gd;
    logic [7:0] exp_b[$];
    mem[24'h000200] = 16'h1122; mem[24'h000201] = 16'h3344;
    lat = 0; uart_time = 0;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    run_dump(24'h000200, 16'd2, 2, 0, bl, gd);
    total_cnt++; if (gd !== 1) $display("FAIL b2b_done_timeout: got %0d expected 1", gd); else pass_cnt++;
    total_cnt++; if (rd_addrs.size() - rd_b !== 2) $display("FAIL b2b_reads: got %0d expected 2", rd_addrs.size() - rd_b); else pass_cnt++;
    total_cnt++; if (tx_bytes.size() - tx_b !== exp_b.size()) $display("FAIL b2b_nbytes: got %0d expected %0d", tx_bytes.size() - tx_b, exp_b.size()); else pass_cnt++;
    for (int k = 0; k < exp_b.size(); k++) begin
      total_cnt++;
      if (tx_b + k >= tx_bytes.size()) $display("FAIL b2b_byte%0d: got none expected %h", k, exp_b[k]);
      else if (tx_bytes[tx_b + k] !== exp_b[k]) $display("FAIL b2b_byte%0d: got %h expected %h", k, tx_bytes[tx_b + k], exp_b[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (tx_cyc.size() < tx_b + 5) $display("FAIL b2b_gap: got %0d strobes expected 5", tx_cyc.size() - tx_b);
    else if (tx_cyc[tx_b + 1] - tx_cyc[tx_b] !== 2 || tx_cyc[tx_b + 3] - tx_cyc[tx_b + 2] !== 2 || tx_cyc[tx_b + 4] - tx_cyc[tx_b + 3] !== 2)
      $display("FAIL b2b_gap: got spacings %0d %0d %0d expected 2 2 2", tx_cyc[tx_b + 1] - tx_cyc[tx_b],
               tx_cyc[tx_b + 3] - tx_cyc[tx_b + 2], tx_cyc[tx_b + 4] - tx_cyc[tx_b + 3]);
    else pass_cnt++;
    // restart in the very cycle after FINISH
    run_dump(24'h000010, 16'd1, -1, 3, bl, gd);
    total_cnt++; if (gd !== 1 || bl !== 0) $display("FAIL restart_accept: got done=%0d busy_low=%0d expected 1 0", gd, bl); else pass_cnt++;
    total_cnt++; if (tx_bytes.size() < tx_b + 3 || tx_bytes[tx_b] !== 8'hA5 || tx_bytes[tx_b + 2] !== 8'hFF)
      $display("FAIL restart_bytes: got %0d bytes expected A5 5A FF", tx_bytes.size() - tx_b); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bl, gd, rst_state, busy_hi;
    logic [7:0] exp_b[$];
    mem[24'h000400] = 16'h0A0B; mem[24'h000401] = 16'h0C0D; mem[24'h000402] = 16'h0E0F; mem[24'h000403] = 16'h1011;
    lat = 1; uart_time = 2;
    rd_b = rd_addrs.size(); tx_b = tx_bytes.size(); dn_b = done_cnt;
    rst_state = 0;
    @(negedge clk); #2;
    start = 1'b1; start_addr = 24'h000400; word_count = 16'd4;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #2;
      start = 1'b0;
      if (rst_state == 1) begin rst_n = 1'b1; rst_state = 2; break; end
      if (tx_cyc.size() == tx_b + 4 && cyc == tx_cyc[tx_b + 3] + 1) begin rst_n = 1'b0; rst_state = 1; end
    end
    total_cnt++; if (rst_state !== 2) $display("FAIL rstmid_reached: got %0d expected 2", rst_state); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else pass_cnt++;
    busy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (busy !== 1'b0) busy_hi++;
    end
    total_cnt++; if (rd_addrs.size() - rd_b !== 2) $display("FAIL rstmid_reads: got %0d expected 2", rd_addrs.size() - rd_b); else pass_cnt++;
    total_cnt++; if (tx_bytes.size() - tx_b !== 4) $display("FAIL rstmid_strobes: got %0d expected 4", tx_bytes.size() - tx_b); else pass_cnt++;
    total_cnt++; if (busy_hi !== 0 || done_cnt - dn_b !== 0) $display("FAIL rstmid_quiet: got busy_hi=%0d done=%0d expected 0 0", busy_hi, done_cnt - dn_b); else pass_cnt++;
    exp_b = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h6C};
    run_dump(24'h000400, 16'd4, -1, 2, bl, gd);
    total_cnt++; if (gd !== 1) $display("FAIL fresh_done_timeout: got %0d expected 1", gd); else pass_cnt++;
    total_cnt++; if (rd_addrs.size() - rd_b !== 4) $display("FAIL fresh_reads: got %0d expected 4", rd_addrs.size() - rd_b); else pass_cnt++;
    total_cnt++; if (tx_bytes.size() - tx_b !== exp_b.size()) $display("FAIL fresh_nbytes: got %0d expected %0d", tx_bytes.size() - tx_b, exp_b.size()); else pass_cnt++;
    for (int k = 0; k < exp_b.size(); k++) begin
      total_cnt++;
      if (tx_b + k >= tx_bytes.size()) $display("FAIL fresh_byte%0d: got none expected %h", k, exp_b[k]);
      else if (tx_bytes[tx_b + k] !== exp_b[k]) $display("FAIL fresh_byte%0d: got %h expected %h", k, tx_bytes[tx_b + k], exp_b[k]);
      else pass_cnt++;
    end
    total_cnt++; if (viol !== 0) $display("FAIL protocol_total: got %0d violations expected 0", viol); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_stall();
    test_wrap();
    test_zero_count();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
